// File: rtl/complex_div_scheduler_pkg.sv
// Shared types for the divider scheduler: op encoding, in-flight tag and writeback entry layout,
// plus the quotient/remainder selection applied at pipe exit.
package complex_div_scheduler_pkg;

  localparam int ROB_W  = 6;
  localparam int PREG_W = 7;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_MOD  = 2'd1,
    OP_DIVU = 2'd2,
    OP_MODU = 2'd3
  } div_op_e;

  typedef struct packed {
    logic              valid;
    div_op_e           op;
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] preg_rd;
    logic              rd_exist;
  } div_tag_t;

  typedef struct packed {
    logic [31:0]       result;
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] preg_rd;
    logic              rd_exist;
  } wb_entry_t;

  // Divider outputs are laid out as {quotient, remainder}.
  function automatic logic [31:0] select_result(input div_op_e op, input logic [63:0] dout_s,
                                                input logic [63:0] dout_u);
    logic [31:0] res;
    unique case (op)
      OP_DIV:  res = dout_s[63:32];
      OP_MOD:  res = dout_s[31:0];
      OP_DIVU: res = dout_u[63:32];
      default: res = dout_u[31:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/complex_div_scheduler_wb_fifo.sv
// Circular writeback buffer for divider results; flush empties it and drops same-cycle push/pop.
// Occupancy is exported so the scheduler can budget credits against it.
module complex_div_scheduler_wb_fifo
  import complex_div_scheduler_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  wb_entry_t        push_data,
  input  logic             ready,
  output logic             valid,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic             full;

  assign valid = (count != '0);
  assign pop   = valid && ready;
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The divider cannot stall, so credit accounting must keep a result from ever meeting a full buffer.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("wb fifo overflow: push into full fifo");

endmodule

// File: rtl/complex_div_scheduler.sv
// Shares one fixed-latency pipelined divider between NUM_REQ issue ports: round-robin grant,
// in-flight tag pipe, quotient/remainder select at exit and a credit-guarded writeback FIFO.
module complex_div_scheduler
  import complex_div_scheduler_pkg::*;
#(
  parameter  int LATENCY       = 4,
  parameter  int NUM_REQ       = 2,
  parameter  int WB_FIFO_DEPTH = 4,
  localparam int SEL_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CRED_W        = $clog2(WB_FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
  input  logic [NUM_REQ*PREG_W-1:0] req_preg_rd,
  input  logic [NUM_REQ-1:0]        req_rd_exist,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [SEL_W-1:0]          div_sel,
  output logic                      div_issue,
  input  logic [63:0]               div_dout_s,
  input  logic [63:0]               div_dout_u,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [31:0]               wb_result,
  output logic [PREG_W-1:0]         wb_preg_rd,
  output logic [ROB_W-1:0]          wb_rob_idx,
  output logic                      wb_rd_exist,
  output logic [CRED_W-1:0]         credits
);

  div_tag_t         tag_pipe [LATENCY];
  div_tag_t         new_tag;
  div_tag_t         last_tag;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic [CRED_W-1:0] fifo_cnt;
  int unsigned      occupied;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;

  // A slot is held from grant until the result leaves the FIFO, so a pop frees it one cycle later.
  always_comb begin
    occupied = 32'(fifo_cnt);
    for (int s = 0; s < LATENCY; s++) occupied += 32'(tag_pipe[s].valid);
  end
  assign credits = CRED_W'(WB_FIFO_DEPTH - occupied);

  // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst && !flush && credits != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[grant_idx] = 1'b1;
  end

  assign div_issue = grant_any;
  assign div_sel   = grant_idx;

  assign new_tag = '{
    valid:    grant_any,
    op:       div_op_e'(req_op[2*int'(grant_idx) +: 2]),
    rob_idx:  req_rob_idx[int'(grant_idx)*ROB_W +: ROB_W],
    preg_rd:  req_preg_rd[int'(grant_idx)*PREG_W +: PREG_W],
    rd_exist: req_rd_exist[grant_idx]
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      if (grant_any) rr_ptr <= (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      tag_pipe[0] <= flush ? '0 : new_tag;
      for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= flush ? '0 : tag_pipe[s-1];
    end
  end

  assign last_tag   = tag_pipe[LATENCY-1];
  assign push_entry = '{
    result:   select_result(last_tag.op, div_dout_s, div_dout_u),
    rob_idx:  last_tag.rob_idx,
    preg_rd:  last_tag.preg_rd,
    rd_exist: last_tag.rd_exist
  };

  complex_div_scheduler_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (last_tag.valid),
    .push_data (push_entry),
    .ready     (wb_ready),
    .valid     (wb_valid),
    .head      (head_entry),
    .count     (fifo_cnt)
  );

  assign wb_result   = head_entry.result;
  assign wb_preg_rd  = head_entry.preg_rd;
  assign wb_rob_idx  = head_entry.rob_idx;
  assign wb_rd_exist = head_entry.rd_exist;

endmodule
